// File: rtl/wallace_mul_arbiter_pkg.sv
// Shared widths, pipeline entry types and the carry-save helper used by the
// Wallace-tree multiplier core.
package wallace_mul_arbiter_pkg;

  localparam int unsigned OPW     = 8;
  localparam int unsigned PRODW   = 16;
  // Widest requester ID supported (NREQ up to 8).
  localparam int unsigned IDW_MAX = 3;

  // S1: registered operands plus owner.
  typedef struct packed {
    logic [OPW-1:0]     a;
    logic [OPW-1:0]     b;
    logic [IDW_MAX-1:0] id;
  } s1_entry_t;

  // S2: registered product plus owner.
  typedef struct packed {
    logic [PRODW-1:0]   prod;
    logic [IDW_MAX-1:0] id;
  } s2_entry_t;

  // One row-level 3:2 compressor output.
  typedef struct packed {
    logic [PRODW-1:0] sum;
    logic [PRODW-1:0] cry;
  } csa_t;

  // 3:2 carry-save add. The carry out of the top bit is dropped; the final
  // product always fits in PRODW bits, so modulo-2^PRODW arithmetic is exact.
  function automatic csa_t csa3(input logic [PRODW-1:0] x,
                                input logic [PRODW-1:0] y,
                                input logic [PRODW-1:0] z);
    csa_t r;
    r.sum = x ^ y ^ z;
    r.cry = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/wallace8_orig.sv
// wallace8_orig: purely combinational 8x8 unsigned Wallace-tree multiplier.
// Ports:
//   a_i   [7:0]  multiplicand
//   b_i   [7:0]  multiplier
//   p_c_o [15:0] full unsigned product (combinational)
module wallace8_orig
  import wallace_mul_arbiter_pkg::*;
(
  input  logic [OPW-1:0]   a_i,
  input  logic [OPW-1:0]   b_i,
  output logic [PRODW-1:0] p_c_o
);

  logic [PRODW-1:0] pp [OPW];
  csa_t l1a, l1b, l2a, l2b, l3, l4;

  // Partial products, each pre-shifted to its weight.
  for (genvar i = 0; i < OPW; i++) begin : g_pp
    assign pp[i] = {PRODW{b_i[i]}} & (PRODW'(a_i) << i);
  end

  // Reduction: 8 -> 6 -> 4 -> 3 -> 2 rows.
  assign l1a = csa3(pp[0], pp[1], pp[2]);
  assign l1b = csa3(pp[3], pp[4], pp[5]);
  assign l2a = csa3(l1a.sum, l1a.cry, l1b.sum);
  assign l2b = csa3(l1b.cry, pp[6], pp[7]);
  assign l3  = csa3(l2a.sum, l2a.cry, l2b.sum);
  assign l4  = csa3(l3.sum, l3.cry, l2b.cry);

  // Final carry-propagate add.
  assign p_c_o = l4.sum + l4.cry;

endmodule

// File: rtl/wmul_rr_arb.sv
// wmul_rr_arb: combinational winner search over req_valid_i.
// Default: first set bit at or above rr_ptr_i, wrapping at NREQ.
// With WMUL_ARB_FIXED_PRIO_EN defined: lowest index wins and there is no
// pointer input.
// Ports:
//   req_valid_i  per-requester valid
//   rr_ptr_i     search start (round-robin build only)
//   en_i         allow a grant this cycle
//   gnt_c_o      one-hot grant (zero when disabled or nothing valid)
//   gnt_idx_c_o  index of the winner (meaningful when gnt_vld_c_o)
//   gnt_vld_c_o  some requester is valid
module wmul_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid_i,
`ifndef WMUL_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]  rr_ptr_i,
`endif
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_c_o,
  output logic [IDW-1:0]  gnt_idx_c_o,
  output logic            gnt_vld_c_o
);

  logic           found_c;
  logic [IDW-1:0] idx_c;
  logic [IDW-1:0] cand_c;
  int unsigned    pos_c;

  // Scan NREQ candidates in priority order; first valid one wins.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    cand_c  = '0;
    pos_c   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef WMUL_ARB_FIXED_PRIO_EN
      pos_c = k;
`else
      // Wrap at NREQ, not 2^IDW, so non-power-of-two NREQ works.
      pos_c = 32'(rr_ptr_i) + k;
      if (pos_c >= NREQ) begin
        pos_c = pos_c - NREQ;
      end
`endif
      cand_c = IDW'(pos_c);
      if (!found_c && req_valid_i[cand_c]) begin
        found_c = 1'b1;
        idx_c   = cand_c;
      end
    end
    gnt_c_o = '0;
    if (en_i && found_c) begin
      gnt_c_o[idx_c] = 1'b1;
    end
    gnt_idx_c_o = idx_c;
    gnt_vld_c_o = found_c;
  end

endmodule

// File: rtl/wallace_mul_arbiter.sv
// wallace_mul_arbiter: shares one wallace8_orig core among NREQ requesters.
// One request is granted per cycle, its operands registered (S1), the core
// output registered (S2), and S2 drives the tagged response port with full
// backpressure. Latency from accept to rsp_valid is two cycles.
// Build option: WMUL_ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration
// and removes the round-robin pointer.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/req_ready per-requester handshake (req_ready is one-hot, comb)
//   req_a/req_b         per-requester operands, slice i = [8i+7:8i]
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_prod     owner index and 16-bit product
//   busy                any pipeline stage occupied
module wallace_mul_arbiter
  import wallace_mul_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [PRODW-1:0]     rsp_prod,
  input  logic                 rsp_ready,
  output logic                 busy
);

  logic      s1_vld_q, s1_vld_d;
  s1_entry_t s1_q, s1_d;
  logic      s2_vld_q, s2_vld_d;
  s2_entry_t s2_q, s2_d;
  logic      busy_q, busy_d;
`ifndef WMUL_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  logic             adv1_c, adv2_c, acc_c;
  logic [NREQ-1:0]  gnt_c;
  logic [IDW-1:0]   gnt_idx_c;
  logic             gnt_vld_c;
  logic [PRODW-1:0] core_prod_c;

  // Stage advance: a stage may load when it is empty or draining.
  assign adv2_c = ~s2_vld_q | rsp_ready;
  assign adv1_c = ~s1_vld_q | adv2_c;
  assign acc_c  = adv1_c & gnt_vld_c;

  wmul_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid_i (req_valid),
`ifndef WMUL_ARB_FIXED_PRIO_EN
    .rr_ptr_i    (rr_ptr_q),
`endif
    .en_i        (adv1_c),
    .gnt_c_o     (gnt_c),
    .gnt_idx_c_o (gnt_idx_c),
    .gnt_vld_c_o (gnt_vld_c)
  );

  // The core only ever sees registered S1 operands.
  wallace8_orig u_core (
    .a_i   (s1_q.a),
    .b_i   (s1_q.b),
    .p_c_o (core_prod_c)
  );

  // Next-state for both pipeline stages and the pointer.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
`ifndef WMUL_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    if (adv2_c) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_d.prod = core_prod_c;
        s2_d.id   = s1_q.id;
      end
    end
    if (adv1_c) begin
      s1_vld_d = acc_c;
      if (acc_c) begin
        s1_d.a  = req_a[32'(gnt_idx_c) * OPW +: OPW];
        s1_d.b  = req_b[32'(gnt_idx_c) * OPW +: OPW];
        s1_d.id = IDW_MAX'(gnt_idx_c);
`ifndef WMUL_ARB_FIXED_PRIO_EN
        rr_ptr_d = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
`endif
      end
    end
    busy_d = s1_vld_d | s2_vld_d;
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_vld_q <= 1'b0;
      s2_q     <= '0;
      busy_q   <= 1'b0;
`ifndef WMUL_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
      s2_vld_q <= s2_vld_d;
      s2_q     <= s2_d;
      busy_q   <= busy_d;
`ifndef WMUL_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign req_ready = gnt_c;
  assign rsp_valid = s2_vld_q;
  assign rsp_id    = IDW'(s2_q.id);
  assign rsp_prod  = s2_q.prod;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Testbench for wallace_mul_arbiter: per-requester operand queues drive the
// ports, a cycle model predicts grants and pipeline occupancy, and a response
// scoreboard holds expected (id, product) pairs in grant order.
module tb_wallace_mul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_prod;
  logic              rsp_ready;
  logic              busy;

  wallace_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    prod;
  } rsp_t;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [15:0]     opq [NREQ][$];
  rsp_t            sb[$];
  int              glog[$];
  logic [15:0]     plog[$];
  logic [NREQ-1:0] acc_n;

  logic            m_s1v, m_s2v;
  int              m_ptr;
  logic            m_adv1, m_adv2, m_found;
  int              m_win;
  logic [NREQ-1:0] exp_ready;
  rsp_t            m_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference grant/occupancy prediction.
  always_comb begin
    m_adv2  = !m_s2v || rsp_ready;
    m_adv1  = !m_s1v || m_adv2;
    m_found = 1'b0;
    m_win   = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef WMUL_ARB_FIXED_PRIO_EN
      if (!m_found && req_valid[k]) begin
        m_found = 1'b1;
        m_win   = k;
      end
`else
      if (!m_found && req_valid[(m_ptr + k) % NREQ]) begin
        m_found = 1'b1;
        m_win   = (m_ptr + k) % NREQ;
      end
`endif
    end
    exp_ready = '0;
    if (m_adv1 && m_found) exp_ready[m_win] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1v <= 1'b0;
      m_s2v <= 1'b0;
      m_ptr <= 0;
      sb.delete();
    end else begin
      if (m_adv2) m_s2v <= m_s1v;
      if (m_adv1) m_s1v <= m_found;
      if (m_adv1 && m_found) begin
        m_e.id   = IDW'(m_win);
        m_e.prod = 16'(req_a[8*m_win +: 8]) * 16'(req_b[8*m_win +: 8]);
        sb.push_back(m_e);
        m_ptr <= (m_win + 1) % NREQ;
      end
    end
  end

  // Per-cycle checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_n <= '0;
    end else begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(m_s1v | m_s2v));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_s2v));
      if (rsp_valid && sb.size() != 0) begin
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk("rsp_prod", 32'(rsp_prod), 32'(sb[0].prod));
        if (rsp_ready) begin
          plog.push_back(rsp_prod);
          void'(sb.pop_front());
        end
      end
      acc_n <= req_valid & req_ready;
      for (int k = 0; k < NREQ; k++)
        if (req_valid[k] && req_ready[k]) glog.push_back(k);
    end
  end

  task automatic apply_ops();
    logic [15:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (opq[i].size() > 0) begin
        e = opq[i][0];
        req_valid[i]    = 1'b1;
        req_a[8*i +: 8] = e[15:8];
        req_b[8*i +: 8] = e[7:0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc_n[i] && opq[i].size() > 0) void'(opq[i].pop_front());
    apply_ops();
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += opq[i].size();
    return n;
  endfunction

  task automatic drain();
    int n = 0;
    while ((busy || sb.size() != 0 || pending() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_busy", 32'(busy), 32'(0));
    chk("drain_sb_empty", 32'(sb.size()), 32'(0));
  endtask

  task automatic push_rand(input int i, input int n);
    for (int k = 0; k < n; k++) opq[i].push_back(16'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int exp_rr[5];
  logic [15:0] exp_corner[3];
  int n3, n0;

  initial begin
`ifdef WMUL_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 2, 3, 0};
`endif
    exp_corner = '{16'h0000, 16'h0080, 16'h4000};
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    acc_n     = '0;

    // Reset values.
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_prod", 32'(rsp_prod), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Round robin with all requesters continuously valid.
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) push_rand(i, 5);
    glog.delete();
    apply_ops();
    drain();
    chk("rr_count", 32'(glog.size()), 32'(20));
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(glog[k]), 32'(exp_rr[k]));

    // Single op, latency and max product.
    opq[2].push_back(16'hFFFF);
    apply_ops();
    tick();
    chk("single_lat1_valid", 32'(rsp_valid), 32'(0));
    tick();
    chk("single_lat2_valid", 32'(rsp_valid), 32'(1));
    chk("single_prod", 32'(rsp_prod), 32'(16'hFE01));
    chk("single_id", 32'(rsp_id), 32'(2));
    drain();

    // Backpressure: two accepts fill the pipe, then grants stop.
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) push_rand(i, 4);
    glog.delete();
    apply_ops();
    for (int k = 0; k < 5; k++) tick();
    chk("bp_accepts", 32'(glog.size()), 32'(2));
    chk("bp_req_ready", 32'(req_ready), 32'(0));
    chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
    rsp_ready = 1'b1;
    drain();
    chk("bp_total", 32'(glog.size()), 32'(16));

    // Corner operands.
    plog.delete();
    opq[1].push_back(16'h00AB);
    opq[1].push_back(16'h0180);
    opq[1].push_back(16'h8080);
    apply_ops();
    drain();
    chk("corner_count", 32'(plog.size()), 32'(3));
    for (int k = 0; k < 3; k++) chk("corner_prod", 32'(plog[k]), 32'(exp_corner[k]));

    // Reset with both stages full.
    rsp_ready = 1'b0;
    push_rand(1, 4);
    apply_ops();
    for (int k = 0; k < 3; k++) tick();
    chk("pre_rst_busy", 32'(busy), 32'(1));
    chk("pre_rst_valid", 32'(rsp_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    for (int i = 0; i < NREQ; i++) opq[i].delete();
    apply_ops();
    tick();
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) push_rand(i, 2);
    glog.delete();
    apply_ops();
    tick();
    chk("postrst_first_grant", 32'(glog.size() > 0 ? glog[0] : -1), 32'(0));
    drain();

    // Requesters 0 and 3 competing.
    push_rand(0, 6);
    push_rand(3, 6);
    glog.delete();
    apply_ops();
    drain();
    n0 = 0;
    n3 = 0;
    for (int k = 0; k < 6; k++) begin
      if (glog[k] == 0) n0++;
      if (glog[k] == 3) n3++;
    end
`ifdef WMUL_ARB_FIXED_PRIO_EN
    chk("fp_req0_grants", 32'(n0), 32'(6));
    chk("fp_req3_grants", 32'(n3), 32'(0));
`else
    chk("rr03_req0_grants", 32'(n0), 32'(3));
    chk("rr03_req3_grants", 32'(n3), 32'(3));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
